// File: rtl/sad_decision_pipe.sv
// sad_decision_pipe
//   Streaming sum-of-absolute-differences unit. Each beat carries LANES
//   unsigned pixels from the frame block and LANES from the window block.
//   Over BEATS beats the per-lane absolute differences are accumulated. A
//   match decision (SAD < threshold) is then issued. When early termination
//   is enabled, the block is abandoned as soon as the running SAD reaches the
//   threshold, and its remaining beats are drained.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   io_in_valid     beat valid
//   io_in_ready     beat accepted when valid && ready
//   io_fBlock       frame pixels, lane i = [i*PIX_W +: PIX_W]
//   io_wBlock       window pixels, same packing
//   io_threshold    match threshold, captured with beat 0
//   io_early_en     early-termination enable, captured with beat 0
//   io_out_valid    result valid
//   io_out_ready    result consumed when valid && ready
//   io_decision     1 = match (SAD < threshold)
//   io_sad          final or partial SAD
//   io_early        result produced by early termination
module sad_decision_pipe #(
   parameter int LANES = 4,
   parameter int PIX_W = 8,
   parameter int BEATS = 16,
   parameter int SAD_W = PIX_W + $clog2(LANES * BEATS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     io_in_valid,
   output logic                     io_in_ready,
   input  logic [LANES*PIX_W-1:0]   io_fBlock,
   input  logic [LANES*PIX_W-1:0]   io_wBlock,
   input  logic [SAD_W-1:0]         io_threshold,
   input  logic                     io_early_en,
   output logic                     io_out_valid,
   input  logic                     io_out_ready,
   output logic                     io_decision,
   output logic [SAD_W-1:0]         io_sad,
   output logic                     io_early
);

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      ST_ACC    = 2'd0,
      ST_RESULT = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t              state_r;
   logic [CNT_W-1:0]    in_cnt_r;
   logic [SAD_W-1:0]    acc_r;
   logic [SAD_W-1:0]    thr_r;
   logic                early_en_r;
   logic                s1_valid_r;
   logic                s1_last_r;
   logic [SAD_W-1:0]    s1_sum_r;
   logic                in_ready_r;
   logic                out_valid_r;
   logic                decision_r;
   logic [SAD_W-1:0]    sad_r;
   logic                early_r;

   logic                accept_s;
   logic                last_beat_s;
   logic [CNT_W-1:0]    cnt_next_s;
   logic [SAD_W-1:0]    beat_sum_s;
   logic [SAD_W-1:0]    nsum_s;

   function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
      if (a >= b) begin
         abs_diff = a - b;
      end else begin
         abs_diff = b - a;
      end
   endfunction

   function automatic logic [SAD_W-1:0] lane_sad(input logic [LANES*PIX_W-1:0] f,
                                                 input logic [LANES*PIX_W-1:0] w);
      logic [SAD_W-1:0] s;
      s = {SAD_W{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         s = s + SAD_W'(abs_diff(f[i*PIX_W +: PIX_W], w[i*PIX_W +: PIX_W]));
      end
      return s;
   endfunction

   // Beat handshake, beat counter successor, incoming lane SAD and running sum.
   always_comb begin
      accept_s    = io_in_valid & in_ready_r;
      last_beat_s = (in_cnt_r == CNT_LAST);
      if (last_beat_s) begin
         cnt_next_s = {CNT_W{1'b0}};
      end else begin
         cnt_next_s = in_cnt_r + CNT_W'(1);
      end
      beat_sum_s = lane_sad(io_fBlock, io_wBlock);
      nsum_s     = acc_r + s1_sum_r;
   end

   // Control FSM, S1 stage, accumulator and registered result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_ACC;
         in_cnt_r    <= {CNT_W{1'b0}};
         acc_r       <= {SAD_W{1'b0}};
         thr_r       <= {SAD_W{1'b0}};
         early_en_r  <= 1'b0;
         s1_valid_r  <= 1'b0;
         s1_last_r   <= 1'b0;
         s1_sum_r    <= {SAD_W{1'b0}};
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         decision_r  <= 1'b0;
         sad_r       <= {SAD_W{1'b0}};
         early_r     <= 1'b0;
      end else begin
         // The beat counter tracks block position even for discarded beats,
         // so the drain knows where the block boundary is.
         if (accept_s) begin
            in_cnt_r <= cnt_next_s;
         end
         case (state_r)
            ST_ACC: begin
               if (s1_valid_r && s1_last_r) begin
                  state_r     <= ST_RESULT;
                  out_valid_r <= 1'b1;
                  sad_r       <= nsum_s;
                  decision_r  <= (nsum_s < thr_r);
                  early_r     <= 1'b0;
                  s1_valid_r  <= 1'b0;
                  in_ready_r  <= 1'b0;
               end else if (s1_valid_r && early_en_r && (nsum_s >= thr_r)) begin
                  // A beat accepted in this cycle belongs to the abandoned
                  // block and is dropped.
                  state_r     <= ST_RESULT;
                  out_valid_r <= 1'b1;
                  sad_r       <= nsum_s;
                  decision_r  <= 1'b0;
                  early_r     <= 1'b1;
                  s1_valid_r  <= 1'b0;
                  in_ready_r  <= 1'b0;
               end else begin
                  if (s1_valid_r) begin
                     acc_r <= nsum_s;
                  end
                  s1_valid_r <= accept_s;
                  if (accept_s) begin
                     s1_sum_r  <= beat_sum_s;
                     s1_last_r <= last_beat_s;
                  end
                  if (accept_s && (in_cnt_r == {CNT_W{1'b0}})) begin
                     thr_r      <= io_threshold;
                     early_en_r <= io_early_en;
                  end
                  // Stop accepting once the last beat sits in S1; the next
                  // block must not start until the result has left.
                  in_ready_r <= !(accept_s && last_beat_s);
               end
            end
            ST_RESULT: begin
               if (io_out_ready) begin
                  out_valid_r <= 1'b0;
                  acc_r       <= {SAD_W{1'b0}};
                  in_ready_r  <= 1'b1;
                  if (in_cnt_r != {CNT_W{1'b0}}) begin
                     state_r <= ST_DRAIN;
                  end else begin
                     state_r <= ST_ACC;
                  end
               end
            end
            ST_DRAIN: begin
               in_ready_r <= 1'b1;
               if (accept_s && last_beat_s) begin
                  state_r <= ST_ACC;
               end
            end
            default: begin
               state_r     <= ST_ACC;
               s1_valid_r  <= 1'b0;
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign io_in_ready  = in_ready_r;
   assign io_out_valid = out_valid_r;
   assign io_decision  = decision_r;
   assign io_sad       = sad_r;
   assign io_early     = early_r;

endmodule

// File: doc/sad_decision_pipe.md
Name: sad_decision_pipe

Overview:
- Parametrised successor of the single-shot SADDC control unit.
- Streams LANES unsigned pixels per beat from the frame block (io_fBlock) and the window block (io_wBlock), and accumulates the sum of absolute differences over BEATS beats per block.
- Issues a per-block match decision against a runtime threshold, with optional early termination.
- Sits between the block fetch logic and the SADDC tree scheduler. Uses ready/valid handshakes on input and output.

Parameters:
- LANES, 4, pixels per beat.
- PIX_W, 8, bits per pixel (unsigned).
- BEATS, 16, beats per block (>=2).
- SAD_W, PIX_W+clog2(LANES*BEATS), accumulator/threshold width. Derived; never overflows.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- io_in_valid  in  1  beat valid
- io_in_ready  out  1  beat accepted when valid&&ready
- io_fBlock  in  LANES*PIX_W  frame pixels; lane i = bits [i*PIX_W +: PIX_W]
- io_wBlock  in  LANES*PIX_W  window pixels, same packing
- io_threshold  in  SAD_W  match threshold; sampled on acceptance of beat 0
- io_early_en  in  1  early-termination enable; sampled with threshold
- io_out_valid  out  1  result valid
- io_out_ready  in  1  result consumed when valid&&ready
- io_decision  out  1  1 = match (SAD < threshold)
- io_sad  out  SAD_W  final or partial SAD
- io_early  out  1  result produced by early termination

Behaviour:
- Reset: all outputs 0, state ACC, in_cnt=0, acc=0, S1 empty. io_in_ready rises the cycle after reset deasserts. Reset mid-block discards everything, with no output.
- S1 stage: on each accepted beat, register lane_sum = sum over lanes of |f_i - w_i|, plus s1_last = (in_cnt==BEATS-1). in_cnt increments mod BEATS on every accepted beat, including drained beats.
- Next cycle, the S1 beat is added into acc: nsum = acc + lane_sum.
- States:
  - ACC: in_ready = !(s1_valid && s1_last).
    - S1 holding the last beat -> RESULT with sad=nsum, decision=(nsum<thr), early=0.
    - Else, if early_en && nsum >= thr -> RESULT with sad=nsum, decision=0, early=1. Any beat accepted in that same cycle is discarded; S1 is cleared.
    - Else acc <= nsum.
  - RESULT: out_valid=1, in_ready=0. Outputs are held stable until out_ready. On handshake, acc is cleared, then:
    - DRAIN if in_cnt != 0;
    - ACC otherwise.
  - DRAIN: in_ready=1. Accepted beats are discarded, with no S1 load. On the beat where in_cnt wraps to 0 -> ACC.
- Latency: last beat accepted at cycle t -> out_valid at t+2. Throughput is 1 beat/cycle within a block. Per-block overhead is 1 bubble cycle plus the RESULT handshake cycle(s).
- Comparison is strict: nsum == thr gives no match (normal) or triggers termination (early).
- An early trigger on beat BEATS-2 whose partner beat BEATS-1 was accepted the same cycle: in_cnt is already 0, so go straight from RESULT to ACC (no DRAIN).
- Threshold/early_en changes mid-block are ignored until the next beat 0.

Test Plan:
- BEATS=4, f=0x10101010, w=0x0C0C0C0C for 4 beats, thr=100, early_en=0, out_ready=1 -> out_valid exactly 2 cycles after last beat; sad=64, decision=1, early=0; in_ready low the cycle after the last beat.
- Same data with thr=64 -> sad=64, decision=0. Same data with thr=65 -> decision=1.
- BEATS=4, beat0 f=0xFFFFFFFF w=0, thr=500, early_en=1, beats streamed continuously -> result sad=1020, decision=0, early=1. Beat1 is discarded; beats 2-3 are drained. The next block's beat0 starts fresh, with acc=0.
- Completed block, out_ready held low 5 cycles -> out_valid, sad and decision stable; in_ready=0 throughout. After the handshake, a new block is accepted the next cycle.
- Mixed lanes: f=0x00FF0A05, w=0xFF000510 (LANES=4, PIX_W=8) -> lane_sum=255+255+5+11=526 per beat. Verify acc over 4 beats = 2104, SAD_W=12 carries it without wrap.
- Reset asserted after beat 2 of a block -> no out_valid. Outputs are 0 the following cycle. A fresh 4-beat block afterwards yields the correct SAD from zero.
